// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial parity transmitter.
// Frame controller states, parity tracker states, start/stop line levels.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic {
    EVEN,
    ODD
  } par_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_tracker.sv
// Running parity of a serial bit stream as a two-state EVEN/ODD machine.
// par updates one cycle after en; clear wins over en.
module parity_tracker
  import serial_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  par_state_t r_state;
  par_state_t w_state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EVEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = EVEN;
    end else if (en && bit_in) begin
      w_state_nxt = (r_state == EVEN) ? ODD : EVEN;
    end
  end

  assign par = (r_state == ODD);

endmodule

// File: rtl/serial_parity_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB-first, parity bit, stop bit,
// each held BIT_CYCLES cycles. Outputs decode registered state only.
module serial_parity_tx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int              BW          = $clog2(DATA_W + 1);
  localparam logic [15:0]     LP_LAST_CYC = 16'(BIT_CYCLES - 1);
  localparam logic [BW-1:0]   LP_LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [15:0]       r_cyc;
  logic [BW-1:0]     r_bit;
  logic              r_done;
  logic              w_last_cyc;
  logic              w_hs;
  logic              w_shift_en;
  logic              w_tx;
  logic              w_par;

  assign w_last_cyc = (r_cyc == LP_LAST_CYC);

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_shift_en  = 1'b0;
    w_tx        = STOP_BIT;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_hs        = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = START_BIT;
        if (w_last_cyc) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_last_cyc) begin
          w_shift_en = 1'b1;
          if (r_bit == LP_LAST_BIT) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        w_tx = w_par ^ PARITY_ODD;
        if (w_last_cyc) w_state_nxt = STOP;
      end
      STOP: begin
        w_tx = STOP_BIT;
        if (w_last_cyc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == STOP) && w_last_cyc;
      if (w_hs) begin
        r_shift <= data_in;
        r_cyc   <= '0;
        r_bit   <= '0;
      end else if (r_state != IDLE) begin
        // Cycle counter wraps every bit period, including out of STOP.
        r_cyc <= w_last_cyc ? 16'd0 : r_cyc + 16'd1;
        if (w_shift_en) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
        end
      end
    end
  end

  parity_tracker u_parity (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_hs),
    .en     (w_shift_en),
    .bit_in (r_shift[0]),
    .par    (w_par)
  );

  assign tx_out    = w_tx;
  assign busy      = (r_state != IDLE);
  assign ready_out = (r_state == IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Three transmitters (even/1, even/4, odd/1) on shared stimulus, checked each cycle
// against a frame-position model, plus literal frame and timing expectations.
module tb_serial_parity_tx;

  localparam int BC0 = 1;
  localparam int BC1 = 4;
  localparam int BC2 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic [2:0] tx_w, busy_w, rdy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_tx #(.DATA_W(8), .BIT_CYCLES(BC0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_w[0]), .tx_out(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_parity_tx #(.DATA_W(8), .BIT_CYCLES(BC1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_w[1]), .tx_out(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_parity_tx #(.DATA_W(8), .BIT_CYCLES(BC2), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_w[2]), .tx_out(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at frame position idx: 0 start, 1..8 data LSB-first, 9 parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int odd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return (^d) ^ odd[0];
    return 1'b1;
  endfunction

  int         bc_of[3]  = '{BC0, BC1, BC2};
  int         odd_of[3] = '{0, 0, 1};
  int         rem[3]    = '{0, 0, 0};
  logic [7:0] fr[3];
  logic       m_done[3] = '{1'b0, 1'b0, 1'b0};
  bit         m_live    = 1'b0;

  // Inputs change just after posedge; outputs and inputs are both stable here.
  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 3; k++) begin
        logic exp_tx;
        exp_tx = (rem[k] > 0) ? frame_bit(fr[k], odd_of[k], (11*bc_of[k] - rem[k]) / bc_of[k]) : 1'b1;
        chk($sformatf("tx%0d", k),    tx_w[k],   exp_tx);
        chk($sformatf("busy%0d", k),  busy_w[k], rem[k] > 0);
        chk($sformatf("ready%0d", k), rdy_w[k],  rem[k] == 0);
        chk($sformatf("done%0d", k),  done_w[k], m_done[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        rem[k]    = 0;
        m_done[k] = 1'b0;
      end else begin
        bit had;
        had = rem[k] > 0;
        if (had) rem[k]--;
        m_done[k] = had && (rem[k] == 0);
        if (!had && valid_in) begin
          fr[k]  = data_in;
          rem[k] = 11 * bc_of[k];
        end
      end
    end
    if (reset) m_live = 1'b1;
  end

  logic c0[64], c1[64], c2[64], d0[64], b1[64], r0[64], r1[64];

  task automatic rec(input int i);
    c0[i] = tx_w[0]; c1[i] = tx_w[1]; c2[i] = tx_w[2];
    d0[i] = done_w[0]; r0[i] = rdy_w[0]; b1[i] = busy_w[1]; r1[i] = rdy_w[1];
  endtask

  function automatic logic [10:0] frame0(input int base);
    logic [10:0] f;
    for (int b = 0; b < 11; b++) f[b] = c0[base + b];
    return f;
  endfunction

  function automatic logic [10:0] frame2(input int base);
    logic [10:0] f;
    for (int b = 0; b < 11; b++) f[b] = c2[base + b];
    return f;
  endfunction

  task automatic send_start(input logic [7:0] d);
    @(posedge clk); #1;
    data_in  = d;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic cap_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec(i);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL wait_idle: timed out after %0d cycles, required idle", t);
    end
    @(posedge clk);
  endtask

  initial begin
    int cnt_busy, cnt_rdy_low, held_bad;
    logic [10:0] f1;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx_w[0], 1'b1);
    chk("rst_ready", rdy_w[0], 1'b1);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_done", done_w[0], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    send_start(8'hA5);
    cap_run(12);
    chk("a5_frame_even", frame0(0), 11'b10101001010);
    chk("a5_frame_odd", frame2(0), 11'b11101001010);
    chk("a5_done_early", d0[10], 1'b0);
    chk("a5_done_at_12", d0[11], 1'b1);
    wait_idle();

    send_start(8'h07);
    cap_run(12);
    chk("p07_even", c0[9], 1'b1);
    wait_idle();

    send_start(8'h00);
    cap_run(12);
    chk("p00_odd", c2[9], 1'b1);
    chk("p00_even", c0[9], 1'b0);
    wait_idle();

    send_start(8'hFF);
    cap_run(12);
    chk("pff_odd", c2[9], 1'b1);
    chk("pff_even", c0[9], 1'b0);
    wait_idle();

    send_start(8'h3C);
    cap_run(46);
    cnt_busy = 0; cnt_rdy_low = 0; held_bad = 0;
    for (int i = 0; i < 46; i++) begin
      if (b1[i]) cnt_busy++;
      if (!r1[i]) cnt_rdy_low++;
    end
    for (int b = 0; b < 11; b++) begin
      f1[b] = c1[4*b];
      for (int j = 1; j < 4; j++) if (c1[4*b + j] !== c1[4*b]) held_bad++;
    end
    chk("bc4_busy_cycles", cnt_busy, 44);
    chk("bc4_ready_low", cnt_rdy_low, 44);
    chk("bc4_frame", f1, 11'b10001111000);
    chk("bc4_held", held_bad, 0);
    wait_idle();

    @(posedge clk); #1;
    data_in  = 8'h11;
    valid_in = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h22;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rec(i);
      if (i == 11) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
      end
    end
    chk("b2b_frame1", frame0(0), 11'b10000100010);
    chk("b2b_gap_done", d0[11], 1'b1);
    chk("b2b_gap_ready", r0[11], 1'b1);
    chk("b2b_frame2", frame0(12), 11'b10001000100);
    chk("b2b_done2", d0[23], 1'b1);
    wait_idle();

    send_start(8'hC3);
    cap_run(5);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy_before", busy_w[0], 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx_w[0], 1'b1);
    chk("mid_rst_busy", busy_w[0], 1'b0);
    chk("mid_rst_ready", rdy_w[0], 1'b1);
    send_start(8'h81);
    cap_run(12);
    chk("after_rst_frame", frame0(0), 11'b10100000010);
    wait_idle();

    send_start(8'h5A);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rec(i);
      if (i < 9) begin
        @(posedge clk); #1;
        valid_in = 1'($urandom_range(0, 1));
        data_in  = 8'($urandom);
      end else if (i == 9) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
      end
    end
    chk("toggle_frame", frame0(0), 11'b10010110100);
    chk("toggle_done", d0[11], 1'b1);
    wait_idle();

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(0, 299) == 0);
      valid_in = ($urandom_range(0, 2) != 0);
      data_in  = 8'($urandom);
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
